// File: rtl/crossbar_pkg.sv
// crossbar_pkg
//   Shared types for the AXI-Stream crossbar.
//   arb_mode_t  : arbitration policy of an output-port arbiter.
//   arb_state_t : packet-lock FSM state of an output-port arbiter.
package crossbar_pkg;

  typedef enum logic {
    ARB_RR    = 1'b0,
    ARB_FIXED = 1'b1
  } arb_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/stream_arbiter_rr_pick.sv
// rr_pick
//   Combinational rotating-priority picker. Searches req starting at index
//   base and wrapping upward; the first set bit wins.
//   Ports:
//     req   in  N   request vector
//     base  in  IW  index searched first
//     found out 1   at least one request set
//     idx   out IW  winning index (0 when nothing found)
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] base,
  output logic          found,
  output logic [IW-1:0] idx
);

  int j;

  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(base) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/stream_arbiter.sv
// stream_arbiter
//   Packet-locked output-port arbiter for one master port of the AXI-Stream
//   crossbar. Picks one of S_DATA_COUNT slave streams whose tdest equals
//   `number`, holds the grant until the beat carrying last, and drives a
//   registered output beat.
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     number       index of this master port (static)
//     s_data_i     slave tdata, S_DATA_COUNT lanes of T_DATA_WIDTH
//     s_dest_i     slave tdest, S_DATA_COUNT lanes of T_DEST_WIDTH
//     s_last_i     slave tlast
//     s_valid_i    slave tvalid
//     s_ready_o    slave tready, one-hot or zero
//     m_data_o     output tdata (registered)
//     m_id_o       source index of the output beat (registered)
//     m_last_o     output tlast (registered)
//     m_valid_o    output tvalid (registered)
//     m_ready_i    downstream tready
//     busy_o       high while a packet grant is held (FSM state LOCK)
//
// Handshake: on every stream a beat moves on the rising edge where valid and
// ready are both high; valid never waits for ready, and a source holds its
// beat stable until it is taken.
module stream_arbiter
  import crossbar_pkg::*;
#(
  parameter int S_DATA_COUNT = 2,
  parameter int M_DATA_COUNT = 3,
  parameter int T_DATA_WIDTH = 8,
  parameter int ARB_MODE     = 0,
  parameter int WEIGHT       = 1,
  localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
  localparam int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [T_DEST_WIDTH-1:0]              number,
  input  logic [T_DATA_WIDTH*S_DATA_COUNT-1:0] s_data_i,
  input  logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_dest_i,
  input  logic [S_DATA_COUNT-1:0]              s_last_i,
  input  logic [S_DATA_COUNT-1:0]              s_valid_i,
  output logic [S_DATA_COUNT-1:0]              s_ready_o,
  output logic [T_DATA_WIDTH-1:0]              m_data_o,
  output logic [T_ID___WIDTH-1:0]              m_id_o,
  output logic                                 m_last_o,
  output logic                                 m_valid_o,
  input  logic                                 m_ready_i,
  output logic                                 busy_o
);

  localparam logic [3:0]              WEIGHT_C = 4'(WEIGHT);
  localparam logic [T_ID___WIDTH-1:0] LAST_IDX = T_ID___WIDTH'(S_DATA_COUNT - 1);
  localparam bit                      IS_FIXED = (ARB_MODE == int'(ARB_FIXED));

  arb_state_t              state_q;
  logic [T_ID___WIDTH-1:0] grant_q;
  logic [T_ID___WIDTH-1:0] ptr_q;
  logic [3:0]              credit_q;

  logic [S_DATA_COUNT-1:0] eligible;
  logic [T_ID___WIDTH-1:0] search_base;
  logic                    pick_found;
  logic [T_ID___WIDTH-1:0] pick_idx;
  logic                    sticky;
  logic                    any_win;
  logic [T_ID___WIDTH-1:0] win_idx;
  logic                    out_free;
  logic                    fire;
  logic [T_DATA_WIDTH-1:0] sel_data;
  logic                    sel_last;

  always_comb begin
    for (int i = 0; i < S_DATA_COUNT; i++) begin
      eligible[i] = s_valid_i[i] &&
                    (s_dest_i[i*T_DEST_WIDTH +: T_DEST_WIDTH] == number);
    end
  end

  // Fixed priority always searches from 0. Round-robin searches from the
  // slot after the last winner, wrapping.
  always_comb begin
    if (IS_FIXED) search_base = '0;
    else if (ptr_q == LAST_IDX) search_base = '0;
    else search_base = ptr_q + 1'b1;
  end

  rr_pick #(
    .N  (S_DATA_COUNT),
    .IW (T_ID___WIDTH)
  ) u_pick (
    .req   (eligible),
    .base  (search_base),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // The last winner may win again while it still has credit. credit_q == 0
  // only after reset, when no source has won yet, so ptr_q is not a real
  // previous winner and the search starts at 0 instead.
  assign sticky  = !IS_FIXED && (credit_q != 4'd0) && (credit_q < WEIGHT_C) &&
                   eligible[ptr_q];
  assign any_win = sticky || pick_found;
  assign win_idx = sticky ? ptr_q : pick_idx;

  // The output register can take a beat when it is empty or being drained.
  assign out_free = ~m_valid_o | m_ready_i;
  assign fire     = (state_q == LOCK) && s_valid_i[grant_q] && out_free;
  assign sel_data = s_data_i[int'(grant_q)*T_DATA_WIDTH +: T_DATA_WIDTH];
  assign sel_last = s_last_i[grant_q];

  always_comb begin
    s_ready_o = '0;
    if (state_q == LOCK) s_ready_o[grant_q] = out_free;
  end

  assign busy_o = (state_q == LOCK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      ptr_q    <= LAST_IDX;
      credit_q <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_win) begin
            state_q <= LOCK;
            grant_q <= win_idx;
            if (!IS_FIXED) begin
              if (sticky) begin
                credit_q <= credit_q + 4'd1;
              end else begin
                ptr_q    <= pick_idx;
                credit_q <= 4'd1;
              end
            end
          end
        end
        LOCK: begin
          // tdest is not re-checked mid-packet; only last ends the lock.
          if (fire && sel_last) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_id_o    <= '0;
      m_last_o  <= 1'b0;
    end else if (fire) begin
      m_valid_o <= 1'b1;
      m_data_o  <= sel_data;
      m_id_o    <= grant_q;
      m_last_o  <= sel_last;
    end else if (m_ready_i) begin
      m_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// tb_stream_arbiter
//   Three instances share clock and reset: g=0 round-robin WEIGHT=1,
//   g=1 round-robin WEIGHT=2, g=2 fixed priority. All serve master port 1.
module tb_stream_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  number;
  logic [15:0] s_data  [3];
  logic [3:0]  s_dest  [3];
  logic [1:0]  s_last  [3];
  logic [1:0]  s_valid [3];
  logic [1:0]  s_ready [3];
  logic [7:0]  m_data  [3];
  logic [0:0]  m_id    [3];
  logic        m_last  [3];
  logic        m_valid [3];
  logic        m_ready [3];
  logic        busy    [3];

  int n_checks = 0;
  int n_fail   = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    stream_arbiter #(
      .S_DATA_COUNT (2),
      .M_DATA_COUNT (3),
      .T_DATA_WIDTH (8),
      .ARB_MODE     ((g == 2) ? 1 : 0),
      .WEIGHT       ((g == 1) ? 2 : 1)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .number    (number),
      .s_data_i  (s_data[g]),
      .s_dest_i  (s_dest[g]),
      .s_last_i  (s_last[g]),
      .s_valid_i (s_valid[g]),
      .s_ready_o (s_ready[g]),
      .m_data_o  (m_data[g]),
      .m_id_o    (m_id[g]),
      .m_last_o  (m_last[g]),
      .m_valid_o (m_valid[g]),
      .m_ready_i (m_ready[g]),
      .busy_o    (busy[g])
    );
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    for (int g = 0; g < 3; g++) begin
      s_valid[g] = 2'b00;
      s_last[g]  = 2'b00;
      s_data[g]  = 16'h0000;
      s_dest[g]  = 4'b0000;
      m_ready[g] = 1'b1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  // Entry = {id, last, data}
  logic [9:0] exp_q[$];
  int         exp_ids[$];

  // Both sources stream `beats`-beat packets to port 1 with data
  // src*64 + packet*4 + beat; the output must follow exp_ids packet order.
  task automatic run_stream(input int g, input int n0, input int n1, input int beats,
                            input int budget);
    int cnt[2];
    int left[2];
    int pk[2];
    int bt[2];
    int cyc;
    logic [9:0] got;
    cnt = '{0, 0};
    exp_q.delete();
    foreach (exp_ids[p]) begin
      for (int b = 0; b < beats; b++)
        exp_q.push_back({exp_ids[p][0], (b == beats - 1),
                         8'(exp_ids[p] * 64 + cnt[exp_ids[p]] * 4 + b)});
      cnt[exp_ids[p]]++;
    end
    left = '{n0, n1};
    pk   = '{0, 0};
    bt   = '{0, 0};
    cyc  = 0;
    while (exp_q.size() > 0 && cyc < budget) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (left[s] > 0) begin
          s_valid[g][s]          = 1'b1;
          s_dest[g][s*2 +: 2]    = 2'd1;
          s_data[g][s*8 +: 8]    = 8'(s * 64 + pk[s] * 4 + bt[s]);
          s_last[g][s]           = (bt[s] == beats - 1);
        end else begin
          s_valid[g][s] = 1'b0;
          s_last[g][s]  = 1'b0;
        end
      end
      #1;
      if (m_valid[g] && m_ready[g]) begin
        got = {m_id[g], m_last[g], m_data[g]};
        check($sformatf("stream_beat_dut%0d", g), 32'(got), 32'(exp_q.pop_front()));
      end
      for (int s = 0; s < 2; s++) begin
        if (s_valid[g][s] && s_ready[g][s]) begin
          bt[s]++;
          if (bt[s] == beats) begin
            bt[s] = 0;
            pk[s]++;
            left[s]--;
          end
        end
      end
      cyc++;
    end
    check($sformatf("stream_done_dut%0d", g), 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    idle_inputs();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  valid;
    logic [3:0]  dest;
    logic [15:0] data;
    logic [1:0]  last;
    logic        mrdy;
    logic [1:0]  exp_ready;
    logic        exp_busy;
    logic        exp_mvalid;
    logic        chk_m;
    logic [7:0]  exp_data;
    logic        exp_id;
    logic        exp_last;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs[NV];

  initial begin
    // Single-beat from source 0 (dest 1, 0xA5)
    vecs[0]  = '{2'b01, 4'b0001, 16'h00A5, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{2'b01, 4'b0001, 16'h00A5, 2'b01, 1'b1, 2'b01, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{2'b00, 4'b0001, 16'h00A5, 2'b01, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1};
    vecs[3]  = '{2'b00, 4'b0001, 16'h00A5, 2'b01, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    // Source 0 -> dest 2 (ignored), source 1 -> dest 1, 3 beats, 3 stalled cycles
    vecs[4]  = '{2'b11, 4'b0110, 16'h1177, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{2'b11, 4'b0110, 16'h1177, 2'b00, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{2'b11, 4'b0110, 16'h1277, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
    vecs[7]  = '{2'b11, 4'b0110, 16'h1277, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
    vecs[8]  = '{2'b11, 4'b0110, 16'h1277, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
    vecs[9]  = '{2'b11, 4'b0110, 16'h1277, 2'b00, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 1'b0};
    vecs[10] = '{2'b11, 4'b0110, 16'h1377, 2'b10, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 1'b0};
    vecs[11] = '{2'b01, 4'b0110, 16'h0077, 2'b00, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 8'h13, 1'b1, 1'b1};
    vecs[12] = '{2'b01, 4'b0110, 16'h0077, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[13] = '{2'b01, 4'b0110, 16'h0077, 2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    number = 2'd1;
    rst_n  = 1'b0;
    idle_inputs();
    #1;
    check("reset_m_valid", 32'(m_valid[0]), 32'd0);
    check("reset_busy", 32'(busy[0]), 32'd0);
    check("reset_s_ready", 32'(s_ready[0]), 32'd0);
    do_reset();

    // Table: single-beat timing, dest filtering, backpressure (instance 0)
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      s_valid[0] = vecs[i].valid;
      s_dest[0]  = vecs[i].dest;
      s_data[0]  = vecs[i].data;
      s_last[0]  = vecs[i].last;
      m_ready[0] = vecs[i].mrdy;
      #1;
      check($sformatf("vec%0d_s_ready", i), 32'(s_ready[0]), 32'(vecs[i].exp_ready));
      check($sformatf("vec%0d_busy", i), 32'(busy[0]), 32'(vecs[i].exp_busy));
      check($sformatf("vec%0d_m_valid", i), 32'(m_valid[0]), 32'(vecs[i].exp_mvalid));
      if (vecs[i].chk_m) begin
        check($sformatf("vec%0d_m_data", i), 32'(m_data[0]), 32'(vecs[i].exp_data));
        check($sformatf("vec%0d_m_id", i), 32'(m_id[0]), 32'(vecs[i].exp_id));
        check($sformatf("vec%0d_m_last", i), 32'(m_last[0]), 32'(vecs[i].exp_last));
      end
    end

    // Round-robin alternation, WEIGHT=1
    do_reset();
    exp_ids = '{0, 1, 0, 1};
    run_stream(0, 2, 2, 2, 100);

    // Weighted round-robin, WEIGHT=2
    do_reset();
    exp_ids = '{0, 0, 1, 1, 0, 0};
    run_stream(1, 4, 2, 2, 100);

    // Fixed priority: source 1 only after source 0 stops
    do_reset();
    exp_ids = '{0, 0, 0, 1, 1};
    run_stream(2, 3, 2, 2, 100);

    // Reset in the middle of a 4-beat packet from source 1
    do_reset();
    @(negedge clk);
    s_valid[0] = 2'b10;
    s_dest[0]  = 4'b0100;
    s_data[0]  = 16'h4000;
    s_last[0]  = 2'b00;
    @(negedge clk);
    #1;
    check("rst_seq_ready", 32'(s_ready[0]), 32'h2);
    @(negedge clk);
    s_data[0] = 16'h4100;
    #1;
    check("rst_seq_beat0", 32'(m_data[0]), 32'h40);
    @(negedge clk);
    s_data[0] = 16'h4200;
    #1;
    check("rst_seq_beat1", 32'(m_data[0]), 32'h41);
    rst_n = 1'b0;
    #1;
    check("rst_async_m_valid", 32'(m_valid[0]), 32'd0);
    check("rst_async_m_data", 32'(m_data[0]), 32'd0);
    check("rst_async_m_id", 32'(m_id[0]), 32'd0);
    check("rst_async_m_last", 32'(m_last[0]), 32'd0);
    check("rst_async_s_ready", 32'(s_ready[0]), 32'd0);
    check("rst_async_busy", 32'(busy[0]), 32'd0);
    s_valid[0] = 2'b11;
    s_dest[0]  = 4'b0101;
    s_data[0]  = 16'h4201;
    s_last[0]  = 2'b11;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("post_rst_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    #1;
    check("post_rst_grant", 32'(s_ready[0]), 32'h1);
    check("post_rst_busy_lock", 32'(busy[0]), 32'd1);
    @(negedge clk);
    s_valid[0] = 2'b10;
    #1;
    check("post_rst_m_valid", 32'(m_valid[0]), 32'd1);
    check("post_rst_m_id", 32'(m_id[0]), 32'd0);
    check("post_rst_m_data", 32'(m_data[0]), 32'h01);
    check("post_rst_m_last", 32'(m_last[0]), 32'd1);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_arbiter.md
# stream_arbiter

Packet-locked output-port arbiter for the AXI-Stream crossbar. One instance per master port: it selects among `S_DATA_COUNT` slave streams addressed to this port (`s_dest_i == number`), holds the grant for a whole packet (until `last`), and drives a registered output beat with data, source id and last. It generalises the existing per-port round-robin selector. It adds a selectable arbitration mode, weighted round-robin, its own data mux and output register, and per-slave ready.

## Interface
- `S_DATA_COUNT`, 2: number of slave (source) streams.
- `M_DATA_COUNT`, 3: number of master ports; sets dest width.
- `T_DATA_WIDTH`, 8: tdata width.
- `ARB_MODE`, 0: 0 = weighted round-robin, 1 = fixed priority (lowest index wins).
- `WEIGHT`, 1: maximum consecutive packets one source may win in RR mode; must be 1..15.
- Localparams: `T_ID___WIDTH = $clog2(S_DATA_COUNT)`, `T_DEST_WIDTH = $clog2(M_DATA_COUNT)`.

- `clk`  in  1  clock; single clock domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `number`  in  T_DEST_WIDTH  index of this master port; static.
- `s_data_i`  in  T_DATA_WIDTH × S_DATA_COUNT  slave tdata.
- `s_dest_i`  in  T_DEST_WIDTH × S_DATA_COUNT  slave tdest.
- `s_last_i`  in  S_DATA_COUNT  slave tlast.
- `s_valid_i`  in  S_DATA_COUNT  slave tvalid.
- `s_ready_o`  out  S_DATA_COUNT  slave tready; one-hot or zero.
- `m_data_o`  out  T_DATA_WIDTH  output tdata (registered).
- `m_id_o`  out  T_ID___WIDTH  source index of the output beat (registered).
- `m_last_o`  out  1  output tlast (registered).
- `m_valid_o`  out  1  output tvalid (registered).
- `m_ready_i`  in  1  downstream tready.
- `busy_o`  out  1  high while a packet grant is held (state LOCK).

## Operation
- A request from source i is eligible when `s_valid_i[i] && s_dest_i[i] == number`.
- The FSM has two states: IDLE and LOCK.
- **IDLE.** If any request is eligible, a winner is picked and stored in `grant` and the FSM moves to LOCK. If none is eligible, it stays in IDLE. `s_ready_o` is 0 in IDLE.
- **Winner selection, fixed priority.** The lowest eligible index wins. `WEIGHT`, `ptr` and `credit` are ignored.
- **Winner selection, weighted round-robin.**
  - If `credit < WEIGHT` and source `ptr` is eligible, `ptr` wins again and `credit` increments.
  - Otherwise the first eligible index searching from `(ptr+1) mod S_DATA_COUNT` upward (wrapping) wins, `ptr` takes the winner's index, and `credit` becomes 1.
- **LOCK.**
  - `s_ready_o[grant] = (~m_valid_o | m_ready_i)`. All other bits of `s_ready_o` are 0.
  - A beat transfers when `s_valid_i[grant] && s_ready_o[grant]`. On transfer, the output register loads `s_data_i[grant]`, `grant`, `s_last_i[grant]`, and `m_valid_o` goes to 1.
  - When the transferred beat has `last = 1`, the FSM returns to IDLE.
  - `s_dest_i[grant]` is not re-checked mid-packet.
- **Output register.** `m_valid_o` clears when `m_ready_i` is high and no new beat loads in the same cycle. It holds, with stable data, while `m_ready_i` is low.
- **Reset values.**
  - FSM = IDLE, `grant` = 0, `ptr` = S_DATA_COUNT-1 (so the first RR search starts at 0), `credit` = 0.
  - `m_valid_o` = 0, `m_last_o` = 0, `m_data_o` = 0, `m_id_o` = 0, `s_ready_o` = 0, `busy_o` = 0.
- **Reset mid-packet.** Asserting reset during a packet abandons the packet immediately. The partially sent packet is not completed.

## Timing
- **Arbitration latency.** A request first eligible in cycle 0 is granted at edge 1. `s_ready_o` is high in cycle 1. The beat is accepted at edge 2, so `m_valid_o` is high from cycle 2.
- **Throughput.** One beat per cycle within a packet while `m_ready_i` stays high.
- **Inter-packet gap.** One cycle between packets, for the return to IDLE.
- **Backpressure.** With `m_ready_i` low and `m_valid_o` high, `s_ready_o` is 0 in the same cycle, so the output register is never overrun.
- **Simultaneous requests.** When several sources become eligible in the same cycle, exactly one is granted. Losers keep `valid` and are not dropped.
- **Single-beat packet** (`last` on the first beat): LOCK lasts exactly one transfer cycle.

## Structure
- Shared package `crossbar_pkg` holds:
  - `arb_mode_t` enum: `ARB_RR = 0`, `ARB_FIXED = 1`.
  - `arb_state_t` enum: `IDLE`, `LOCK`.
- Sub-module `rr_pick`: combinational rotating-priority picker.
  - Inputs: request vector and base index.
  - Outputs: `found` and index.
  - Fixed priority uses base = 0.
- The top level holds the FSM, the `ptr`/`credit` registers, the data mux and the output register.

## Test plan
- **Basic single-beat.** S=2, M=3, number=1, RR, WEIGHT=1. Source 0 sends a single-beat packet with dest 1 and data 0xA5. Required: `m_valid_o` high in cycle 2 with data 0xA5, id 0, last 1; `busy_o` low again in cycle 2.
- **Round-robin alternation.** Both sources continuously send 2-beat packets to dest 1. Required: packet ids on the output alternate 0, 1, 0, 1, and beats within a packet are never interleaved.
- **Weighting.** As the alternation scenario but with WEIGHT=2. Required: id sequence 0, 0, 1, 1, 0, 0.
- **Fixed priority.** ARB_MODE=1 with both sources requesting. Required: all source-0 packets are output first; source 1 is granted only once `s_valid_i[0]` drops.
- **Dest filtering and backpressure.** Source 0 sends to dest 2 and is never granted. Source 1 sends a 3-beat packet while `m_ready_i` is low for 3 cycles. Required: `m_data_o` is stable throughout, `s_ready_o` = 0 while stalled, and all 3 beats arrive in order.
- **Reset mid-packet.** Drop `rst_n` during beat 2 of a 4-beat packet. Required: all outputs at their reset values asynchronously; after release, the next grant goes to source 0.
